// File: rtl/maxpool_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : maxpool_pkg
//  Purpose  : Shared definitions for the 2x2 max-pool controller. Holds the
//             FP16 width constant, the controller state type and the
//             optional ReLU clamp helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package maxpool_pkg;

    localparam int c_fp16_w = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVEN  = 2'd1,
        S_ODD   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    // Negative results (sign bit set, including -0) become +0.
    function automatic logic [c_fp16_w-1:0] relu_clamp(input logic [c_fp16_w-1:0] x);
        return x[c_fp16_w-1] ? '0 : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool_ctrl_pool2x2.sv
`default_nettype none
// ============================================================================
//  Module   : maxpool_ctrl_pool2x2
//  Purpose  : Combinational maximum of four FP16 values (one 2x2 window).
//  Ports    : a, b     - top-row pixels of the window
//             c, d     - bottom-row pixels of the window
//             y        - largest of the four
//  Revision : 1.0  initial release
// ============================================================================
module maxpool_ctrl_pool2x2
    import maxpool_pkg::*;
(
    input  logic [c_fp16_w-1:0] a,
    input  logic [c_fp16_w-1:0] b,
    input  logic [c_fp16_w-1:0] c,
    input  logic [c_fp16_w-1:0] d,
    output logic [c_fp16_w-1:0] y
);

    // Map sign-magnitude FP16 onto an unsigned key whose ordering matches the
    // numeric ordering: positives get the top bit set, negatives are inverted
    // so larger magnitudes sort lower.
    function automatic logic [c_fp16_w-1:0] order_key(input logic [c_fp16_w-1:0] x);
        return x[c_fp16_w-1] ? ~x : {1'b1, x[c_fp16_w-2:0]};
    endfunction

    logic [c_fp16_w-1:0] w_top;
    logic [c_fp16_w-1:0] w_bot;

    assign w_top = (order_key(a) >= order_key(b)) ? a : b;
    assign w_bot = (order_key(c) >= order_key(d)) ? c : d;
    assign y     = (order_key(w_top) >= order_key(w_bot)) ? w_top : w_bot;

endmodule
`default_nettype wire

// File: rtl/maxpool_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : maxpool_ctrl
//  Purpose  : Streaming 2x2/stride-2 max-pool over an IMG_W x IMG_H FP16
//             feature map delivered in raster order. Even rows are parked in
//             a line buffer; odd rows complete each window, whose maximum is
//             registered into a single output stage.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             start                 - begins one frame (idle only)
//             in_data/valid/ready   - pixel input stream
//             out_data/valid/ready  - pooled output stream
//             busy                  - frame in progress
//             done                  - pulses with the final output handshake
//  Config   : MAXPOOL_RELU_EN - clamp negative results to +0
//  Revision : 1.0  initial release
// ============================================================================
module maxpool_ctrl
    import maxpool_pkg::*;
#(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [c_fp16_w-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [c_fp16_w-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] c_col_one  = COL_W'(1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] c_row_one  = ROW_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [c_fp16_w-1:0] r_lbuf [IMG_W];
    logic [c_fp16_w-1:0] r_hold;
    logic [c_fp16_w-1:0] r_out_data;
    logic                r_out_valid;

    logic                w_streaming;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_col_last;
    logic                w_row_last;
    logic                w_load;
    logic                w_out_hs;
    logic [COL_W-1:0]    w_col_even;
    logic [c_fp16_w-1:0] w_max;
    logic [c_fp16_w-1:0] w_result;

    assign w_streaming = (r_state == S_EVEN) || (r_state == S_ODD);
    // One output register: input may advance whenever that register is free
    // or being drained in this same cycle.
    assign w_in_ready  = w_streaming && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && w_in_ready;
    assign w_col_last  = (r_col == c_col_last);
    assign w_row_last  = (r_row == c_row_last);
    assign w_col_even  = r_col & ~c_col_one;
    assign w_load      = w_accept && (r_state == S_ODD) && r_col[0];
    assign w_out_hs    = r_out_valid && out_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_EVEN;
            S_EVEN:  if (w_accept && w_col_last) w_state_nxt = S_ODD;
            S_ODD:   if (w_accept && w_col_last)
                         w_state_nxt = w_row_last ? S_FLUSH : S_EVEN;
            S_FLUSH: if (w_out_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Column / row counters advance only on accepted pixels
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            r_col <= w_col_last ? '0 : r_col + c_col_one;
            if (w_col_last) begin
                r_row <= w_row_last ? '0 : r_row + c_row_one;
            end
        end
    end

    // Line buffer is never reset: every entry is written on the even row
    // before the odd row reads it.
    always_ff @(posedge clk) begin
        if (w_accept && (r_state == S_EVEN)) begin
            r_lbuf[r_col] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (w_accept && (r_state == S_ODD) && !r_col[0]) begin
            r_hold <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Window reduction and output register
    // ------------------------------------------------------------------
    maxpool_ctrl_pool2x2 u_pool (
        .a (r_lbuf[w_col_even]),
        .b (r_lbuf[r_col]),
        .c (r_hold),
        .d (in_data),
        .y (w_max)
    );

`ifdef MAXPOOL_RELU_EN
    assign w_result = relu_clamp(w_max);
`else
    assign w_result = w_max;
`endif

    // A new result takes priority over a simultaneous drain so out_valid
    // stays high across back-to-back windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != S_IDLE);
    // The final window is the only output still pending in S_FLUSH.
    assign done      = (r_state == S_FLUSH) && w_out_hs;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_maxpool_ctrl
//  Purpose  : Self-checking bench for maxpool_ctrl on a 4x4 frame. Table
//             windows, a ramp frame, backpressure, reset mid-frame, start
//             while busy and random frames against a value-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_maxpool_ctrl;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int NWIN = (W / 2) * (H / 2);

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [15:0] in_data, out_data;

    always #5 clk = ~clk;

    maxpool_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          frame_out = 0;
    logic [15:0] exp_q [$];
    logic [15:0] frame [NPIX];
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic [15:0] mon_exp;

    typedef struct {
        logic [15:0] a, b, c, d;
        logic [15:0] exp_max;
        logic [15:0] exp_relu;
    } vec_t;

    // FP16 value scaled by 2^24 so every finite value is an exact integer.
    function automatic longint fp16_val(input logic [15:0] x);
        int     e;
        int     m;
        longint mag;
        e   = int'(x[14:10]);
        m   = int'(x[9:0]);
        mag = (e == 0) ? longint'(m) : (longint'(1024 + m) <<< (e - 1));
        return x[15] ? -mag : mag;
    endfunction

    function automatic logic [15:0] model_win(input logic [15:0] a, b, c, d);
        logic [15:0] w [4];
        logic [15:0] best;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        best = w[0];
        for (int i = 1; i < 4; i++)
            if (fp16_val(w[i]) > fp16_val(best)) best = w[i];
`ifdef MAXPOOL_RELU_EN
        if (fp16_val(best) < 0) best = 16'h0000;
`endif
        return best;
    endfunction

    function automatic logic [15:0] rand_px();
        logic [15:0] x;
        x = 16'($urandom);
        if (x[14:10] == 5'h1f) x[14] = 1'b0;   // keep finite
        return x;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Output monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            frame_out  = 0;
        end else begin
            if (prev_stall)
                chk(out_valid && (out_data == prev_data), "hold", out_data, prev_data);
            if (out_valid && !out_ready)
                chk(!in_ready, "in_ready_stall", {15'd0, in_ready}, 16'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "spurious_out", out_data, 16'h0000);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk(fp16_val(out_data) == fp16_val(mon_exp), "window", out_data, mon_exp);
                end
                frame_out++;
                chk(done == (frame_out == NWIN), "done", {15'd0, done}, {15'd0, frame_out == NWIN});
                if (frame_out == NWIN) begin
                    frame_out = 0;
                    done_cnt++;
                end
            end else if (done) begin
                chk(1'b0, "done_stray", 16'd1, 16'd0);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // Runs one frame from the frame[] array. Starts at posedge+1.
    task automatic run_frame(input int vpct, input int rpct, input int stall_at,
                             input int stall_len, input int glitch_idx, input bit use_model);
        int d0;
        int idx;
        int cyc;
        int c;
        bit acc;
        bit glitched;
        if (use_model)
            for (int r = 0; r < H / 2; r++)
                for (int cc = 0; cc < W / 2; cc++)
                    exp_q.push_back(model_win(frame[2*r*W + 2*cc], frame[2*r*W + 2*cc + 1],
                                              frame[(2*r+1)*W + 2*cc], frame[(2*r+1)*W + 2*cc + 1]));
        d0       = done_cnt;
        idx      = 0;
        glitched = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fork
            begin
                cyc = 0;
                while (idx < NPIX && cyc < 2000) begin
                    in_valid = ($urandom_range(99) < vpct);
                    in_data  = in_valid ? frame[idx] : rand_px();
                    start    = !glitched && (idx == glitch_idx);
                    if (start) glitched = 1'b1;
                    @(negedge clk);
                    acc = in_valid && in_ready;
                    @(posedge clk); #1;
                    if (acc) idx++;
                    cyc++;
                end
                in_valid = 1'b0;
                start    = 1'b0;
            end
            begin
                c = 0;
                while (done_cnt == d0 && c < 3000) begin
                    out_ready = (c >= stall_at && c < stall_at + stall_len) ? 1'b0
                              : ($urandom_range(99) < rpct);
                    @(posedge clk); #1;
                    c++;
                end
                out_ready = 1'b1;
            end
        join
        chk(idx == NPIX, "in_timeout", 16'(idx), 16'(NPIX));
        chk(done_cnt - d0 == 1, "done_count", 16'(done_cnt - d0), 16'd1);
        chk(exp_q.size() == 0, "out_count", 16'(exp_q.size()), 16'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk(!busy, "idle_after", {15'd0, busy}, 16'd0);
    endtask

    vec_t        tbl [8];
    logic [15:0] ramp [NPIX];

    initial begin
        tbl[0] = '{16'hC000, 16'hBC00, 16'hC200, 16'hB800, 16'hB800, 16'h0000};
        tbl[1] = '{16'h3C00, 16'h4000, 16'h4200, 16'h3800, 16'h4200, 16'h4200};
        tbl[2] = '{16'hC400, 16'h3400, 16'hBC00, 16'h0000, 16'h3400, 16'h3400};
        tbl[3] = '{16'h7BFF, 16'hFBFF, 16'h0001, 16'h8001, 16'h7BFF, 16'h7BFF};
        tbl[4] = '{16'h0001, 16'h0002, 16'h8003, 16'h0000, 16'h0002, 16'h0002};
        tbl[5] = '{16'h4500, 16'h4500, 16'h4400, 16'h4480, 16'h4500, 16'h4500};
        tbl[6] = '{16'hBC00, 16'hBC01, 16'hBE00, 16'hC000, 16'hBC00, 16'h0000};
        tbl[7] = '{16'h5640, 16'h1234, 16'h5641, 16'h5000, 16'h5641, 16'h5641};
        ramp = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700,
                 16'h4800, 16'h4880, 16'h4900, 16'h4980, 16'h4A00, 16'h4A80, 16'h4B00, 16'h4B80};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(!out_valid, "rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk(out_data == 16'h0000, "rst_out_data", out_data, 16'h0000);
        chk(!busy, "rst_busy", {15'd0, busy}, 16'd0);
        chk(!in_ready, "rst_in_ready", {15'd0, in_ready}, 16'd0);
        chk(!done, "rst_done", {15'd0, done}, 16'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven windows: four records per frame, full rate.
        for (int f = 0; f < 2; f++) begin
            for (int w = 0; w < NWIN; w++) begin
                int base;
                base = 2 * (w / 2) * W + 2 * (w % 2);
                frame[base]         = tbl[f*4 + w].a;
                frame[base + 1]     = tbl[f*4 + w].b;
                frame[base + W]     = tbl[f*4 + w].c;
                frame[base + W + 1] = tbl[f*4 + w].d;
`ifdef MAXPOOL_RELU_EN
                exp_q.push_back(tbl[f*4 + w].exp_relu);
`else
                exp_q.push_back(tbl[f*4 + w].exp_max);
`endif
            end
            run_frame(100, 100, -1, 0, -1, 1'b0);
        end

        // Ramp 0..15: maxima are pixels 5, 7, 13, 15.
        frame = ramp;
        exp_q.push_back(16'h4500); exp_q.push_back(16'h4700);
        exp_q.push_back(16'h4A80); exp_q.push_back(16'h4B80);
        run_frame(100, 100, -1, 0, -1, 1'b0);

        // Same ramp with in_valid toggling at 50%.
        frame = ramp;
        run_frame(50, 100, -1, 0, -1, 1'b1);

        // out_ready held low for 10 cycles while the first window is pending.
        for (int i = 0; i < NPIX; i++) frame[i] = rand_px();
        run_frame(100, 100, 6, 10, -1, 1'b1);

        // start pulsed during an odd row must be ignored.
        for (int i = 0; i < NPIX; i++) frame[i] = rand_px();
        run_frame(100, 100, -1, 0, 6, 1'b1);

        // Reset after six pixels, while the first window is valid.
        for (int i = 0; i < NPIX; i++) frame[i] = rand_px();
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = frame[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk(out_valid, "pre_reset_valid", {15'd0, out_valid}, 16'd1);
        #1 rst_n = 1'b0;
        #1;
        chk(!out_valid, "mid_rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk(!busy, "mid_rst_busy", {15'd0, busy}, 16'd0);
        chk(!in_ready, "mid_rst_in_ready", {15'd0, in_ready}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NPIX; i++) frame[i] = rand_px();
        run_frame(100, 100, -1, 0, -1, 1'b1);

        // Random frames with random input gaps and output backpressure.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NPIX; i++) frame[i] = rand_px();
            run_frame(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), -1, 0, -1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
